// File: rtl/num_feeder.sv
// Circular symbol FIFO feeding a downstream detector's 2-bit num input.
// Optional macro NUM_FEEDER_ZERO_FILTER_EN drops incoming 2'b00 symbols.
module num_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [1:0]    in_data,
  output logic          in_ready,
  input  logic          out_en,
  output logic [1:0]    num,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow
);

  localparam int unsigned   CW   = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_sym_ok;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

`ifdef NUM_FEEDER_ZERO_FILTER_EN
  assign w_sym_ok = (in_data != 2'b00);
`else
  assign w_sym_ok = 1'b1;
`endif

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == CW'(0));
  assign w_push  = in_valid && !w_full && w_sym_ok;
  assign w_pop   = out_en && !w_empty;

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (in_valid && w_full && w_sym_ok) r_overflow <= 1'b1;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  assign num      = w_empty ? 2'b00 : r_mem[r_rd_ptr];
  assign in_ready = !w_full;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_num_feeder.sv
// Self-checking bench for num_feeder: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_num_feeder;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [1:0]    in_data;
  logic          in_ready;
  logic          out_en;
  logic [1:0]    num;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;

  num_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_en(out_en), .num(num), .count(count),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       e;
    logic [1:0] x_num;
    int         x_cnt;
    logic       x_ovf;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO contents as a queue plus sticky overflow
  logic [1:0] m_q[$];
  logic       m_ovf;

  function automatic bit sym_ok(input logic [1:0] d);
`ifdef NUM_FEEDER_ZERO_FILTER_EN
    return d != 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string name, input logic [1:0] x_num, input int x_cnt, input logic x_ovf);
    logic x_empty, x_full;
    x_empty = (x_cnt == 0);
    x_full  = (x_cnt == int'(DEPTH));
    n_vec++;
    if (num !== x_num || int'(count) != x_cnt || empty !== x_empty || full !== x_full ||
        in_ready !== !x_full || overflow !== x_ovf) begin
      n_err++;
      $display("FAIL %s @%0t: got num=%b count=%0d empty=%b full=%b in_ready=%b overflow=%b; want num=%b count=%0d empty=%b full=%b in_ready=%b overflow=%b",
               name, $time, num, count, empty, full, in_ready, overflow,
               x_num, x_cnt, x_empty, x_full, !x_full, x_ovf);
    end
  endtask

  task automatic chk_m(input string name);
    chk(name, (m_q.size() > 0) ? m_q[0] : 2'b00, m_q.size(), m_ovf);
  endtask

  // One clock: drive at negedge, optionally check pre-edge view, then update model past the edge
  task automatic step(input logic v, input logic [1:0] d, input logic e, input bit pre);
    bit was_full, push, pop;
    @(negedge clk);
    in_valid = v; in_data = d; out_en = e;
    if (pre) begin
      #1;
      chk_m("pre_edge");
    end
    @(posedge clk);
    was_full = (m_q.size() == int'(DEPTH));
    push = v && !was_full && sym_ok(d);
    pop  = e && (m_q.size() > 0);
    if (v && was_full && sym_ok(d)) m_ovf = 1'b1;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = 2'b00; out_en = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge
  task automatic async_reset(input string name);
    @(posedge clk);
    #2 reset = 1'b1;
    m_q.delete();
    m_ovf = 1'b0;
    #1 chk(name, 2'b00, 0, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
  endtask

  function automatic logic [1:0] pat(input int i);
    return 2'((i % 3) + 1);
  endfunction

  vec_t tbl[6];

  initial begin
    reset = 1'b1;
    idle_inputs();
    m_ovf = 1'b0;

    tbl[0] = '{1'b1, 2'b01, 1'b0, 2'b01, 1, 1'b0};
    tbl[1] = '{1'b1, 2'b10, 1'b0, 2'b01, 2, 1'b0};
    tbl[2] = '{1'b1, 2'b11, 1'b0, 2'b01, 3, 1'b0};
    tbl[3] = '{1'b0, 2'b00, 1'b1, 2'b10, 2, 1'b0};
    tbl[4] = '{1'b0, 2'b00, 1'b1, 2'b11, 1, 1'b0};
    tbl[5] = '{1'b0, 2'b00, 1'b1, 2'b00, 0, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 2'b00, 0, 1'b0);
    reset = 1'b0;

    // Basic write-then-drain table
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].e, 1'b0);
      chk($sformatf("table_%0d", i), tbl[i].x_num, tbl[i].x_cnt, tbl[i].x_ovf);
    end

    // Fill to full, then a dropped write sets sticky overflow
    async_reset("reset_fill");
    for (int i = 0; i < int'(DEPTH); i++) begin
      step(1'b1, pat(i), 1'b0, 1'b0);
      chk($sformatf("fill_%0d", i), 2'b01, i + 1, 1'b0);
    end
    step(1'b1, 2'b11, 1'b0, 1'b0);
    chk("write_when_full", 2'b01, int'(DEPTH), 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("overflow_sticky", 2'b01, int'(DEPTH), 1'b1);

    // Full with write and pop together: write dropped, count drops by one
    async_reset("reset_fullpop");
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, pat(i), 1'b0, 1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b0);
    chk("full_write_pop", pat(1), int'(DEPTH) - 1, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0);
    chk("full_write_pop_hold", pat(1), int'(DEPTH) - 1, 1'b1);

    // Steady count of 3 with simultaneous push/pop across pointer wrap
    async_reset("reset_stream");
    for (int i = 0; i < 3; i++) step(1'b1, pat(i), 1'b0, 1'b0);
    chk("stream_prefill", pat(0), 3, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, pat(k + 2), 1'b1, 1'b0);
      chk($sformatf("stream_%0d", k), pat(k), 3, 1'b0);
    end

    // Pop while empty is ignored, then mid-stream asynchronous reset
    async_reset("reset_empty");
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("pop_empty", 2'b00, 0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0);
    chk("after_empty_pop", 2'b10, 1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
    chk("count_five", 2'b10, 5, 1'b0);
    async_reset("reset_midstream");
    step(1'b1, 2'b01, 1'b0, 1'b0);
    chk("post_reset_write", 2'b01, 1, 1'b0);

    // Zero-symbol handling depends on the filter option
    async_reset("reset_zero");
    step(1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b0, 1'b0);
`ifdef NUM_FEEDER_ZERO_FILTER_EN
    chk("zero_written", 2'b01, 2, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("zero_pop1", 2'b10, 1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("zero_pop2", 2'b00, 0, 1'b0);
`else
    chk("zero_written", 2'b01, 3, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("zero_pop1", 2'b00, 2, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("zero_pop2", 2'b10, 1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("zero_pop3", 2'b00, 0, 1'b0);
`endif

    // Randomized traffic in phases biased toward filling, draining and balance
    async_reset("reset_random");
    for (int ph = 0; ph < 4; ph++) begin
      int pv, pe;
      pv = (ph % 2 == 0) ? 80 : 30;
      pe = (ph % 2 == 0) ? 30 : 80;
      if (ph == 3) begin pv = 55; pe = 55; end
      for (int c = 0; c < 400; c++) begin
        logic v, e;
        logic [1:0] d;
        v = ($urandom_range(0, 99) < pv);
        e = ($urandom_range(0, 99) < pe);
        d = 2'($urandom_range(0, 3));
        step(v, d, e, 1'b1);
        chk_m("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/num_feeder.md
NUM_FEEDER -- requirements
Module: num_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, 2..64.
REQ-002 SHALL have parameter AW, default 3, pointer width = log2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer presents a symbol this cycle.
REQ-006 SHALL have port in_data  input  2  symbol from producer.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a symbol; equals !full.
REQ-008 SHALL have port out_en  input  1  downstream detector consumes the current symbol this cycle.
REQ-009 SHALL have port num  output  2  symbol to the downstream detector's num input.
REQ-010 SHALL have port count  output  AW+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port empty  output  1  count == 0.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-014 SHALL be a circular FIFO with registered write pointer, read pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-015 SHALL accept a write when in_valid && in_ready; the symbol is stored at the write pointer on that edge.
REQ-016 SHALL drive num combinationally from the head entry when !empty, and drive 2'b00 (downstream hold symbol) when empty.
REQ-017 SHALL pop on out_en && !empty; pop while empty is ignored; state and num stay unchanged.
REQ-018 SHALL make a written symbol visible on num no earlier than the cycle after the write (write-to-num latency 1 cycle, no fall-through).
REQ-019 SHALL keep count unchanged on simultaneous accepted write and pop; both pointers advance.
REQ-020 SHALL, when full, deassert in_ready even if out_en is high the same cycle; a write attempted then is dropped.
REQ-021 SHALL set overflow on the edge after in_valid && full and hold it until reset.
REQ-022 SHALL never let count exceed DEPTH or go below 0.

Reset
REQ-023 SHALL on reset assertion immediately (asynchronously) clear pointers and count, and clear overflow; reset mid-stream discards all stored symbols.
REQ-024 SHALL present during/after reset: num=2'b00, count=0, empty=1, full=0, in_ready=1, overflow=0; storage array contents need not be reset.

Configuration
REQ-025 SHALL support macro NUM_FEEDER_ZERO_FILTER_EN.
REQ-026 SHALL, with NUM_FEEDER_ZERO_FILTER_EN defined, discard input symbols equal to 2'b00: no write, no pointer change, in_ready unaffected, overflow not set by a 2'b00 write while full.
REQ-027 SHALL, without the macro, store 2'b00 like any other symbol.

Verification
REQ-028 SHALL cover: reset, write 01,10,11 on 3 cycles, out_en=1 from cycle 4 -> num sequence 01,10,11 then 00; count 1,2,3,2,1,0.
REQ-029 SHALL cover: write 8 symbols with out_en=0 -> full=1, in_ready=0, count=8; 9th write dropped, overflow=1 next edge and stays 1.
REQ-030 SHALL cover: full FIFO with in_valid=1 and out_en=1 together -> write dropped, count 8->7, overflow=1.
REQ-031 SHALL cover: count=3 with simultaneous write and pop for 10 cycles -> count stays 3, order preserved across pointer wrap.
REQ-032 SHALL cover: out_en=1 while empty -> num=00, count=0, no pointer movement; then reset asserted mid-stream at count=5 -> count=0, empty=1 without waiting for clk.
REQ-033 SHALL cover: NUM_FEEDER_ZERO_FILTER_EN defined, write 01,00,10 -> count=2, num sequence 01,10; undefined -> count=3, num 01,00,10.
